// File: rtl/icon_hit_pkg.sv
// Shared types and helpers for the icon hit arbiter: FSM states, default colour
// width and the circular round-robin selector.
package icon_hit_pkg;

    localparam int unsigned DEF_COLOR_W = 12;
    localparam int unsigned MAX_SPRITES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    // First set bit of pending at or after rr_ptr, wrapping at n (n <= MAX_SPRITES).
    function automatic logic [2:0] next_rr(
        input logic [7:0]  pending,
        input logic [2:0]  rr_ptr,
        input int unsigned n
    );
        logic [2:0] sel;
        logic       found;
        logic [3:0] idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_SPRITES; k++) begin
            idx = {1'b0, rr_ptr} + 4'(k);
            if (idx >= 4'(n))
                idx = idx - 4'(n);
            if (k < n && !found && pending[idx[2:0]]) begin
                sel   = idx[2:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/icon_prio_mux.sv
// Registered fixed-priority merge of sprite colour layers; lowest index wins.
module icon_prio_mux
    import icon_hit_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned COLOR_W     = DEF_COLOR_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SPRITES*COLOR_W-1:0] icon_in,
    input  logic [NUM_SPRITES-1:0]         icon_flag_in,
    output logic [COLOR_W-1:0]             pix_color,
    output logic                           pix_valid
);

    logic [COLOR_W-1:0] nxt_color;
    logic               nxt_valid;

    always_comb begin
        nxt_color = '0;
        nxt_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (icon_flag_in[i] && !nxt_valid) begin
                nxt_color = icon_in[i*COLOR_W +: COLOR_W];
                nxt_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_color <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_color <= nxt_color;
            pix_valid <= nxt_valid;
        end
    end

endmodule

// File: rtl/icon_hit_arbiter.sv
// Sprite pixel merge plus per-frame collision accumulation and round-robin tank_hit issue.
// Optional macro ICON_HIT_SPRITE_COLLIDE_EN adds sprite-vs-sprite collisions and overlap_seen.
module icon_hit_arbiter
    import icon_hit_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned COLOR_W     = DEF_COLOR_W,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           video_on,
    input  logic                           frame_start,
    input  logic [NUM_SPRITES*COLOR_W-1:0] icon_in,
    input  logic [NUM_SPRITES-1:0]         icon_flag_in,
    input  logic                           shell_flag,
    input  logic [NUM_SPRITES-1:0]         tank_reset_in,
    output logic [COLOR_W-1:0]             pix_color,
    output logic                           pix_valid,
    output logic [NUM_SPRITES-1:0]         tank_hit,
    output logic [NUM_SPRITES-1:0]         armed,
    output logic [CNT_W-1:0]               hit_count,
    output logic                           busy
`ifdef ICON_HIT_SPRITE_COLLIDE_EN
    ,
    output logic                           overlap_seen
`endif
);

    localparam int unsigned RR_W = $clog2(NUM_SPRITES);

    state_t                 state;
    logic [NUM_SPRITES-1:0] coll_acc;
    logic [NUM_SPRITES-1:0] coll_now;
    logic [NUM_SPRITES-1:0] pending;
    logic [NUM_SPRITES-1:0] sel_onehot;
    logic [RR_W-1:0]        rr_ptr;
    logic [RR_W-1:0]        sel_idx;
    logic [RR_W-1:0]        rr_next;
    logic [7:0]             pend8;
    logic [2:0]             rr8;
    logic                   frame_pend;
`ifdef ICON_HIT_SPRITE_COLLIDE_EN
    logic                   overlap_now;
`endif

    icon_prio_mux #(
        .NUM_SPRITES (NUM_SPRITES),
        .COLOR_W     (COLOR_W)
    ) u_mux (
        .clk          (clk),
        .reset        (reset),
        .icon_in      (icon_in),
        .icon_flag_in (icon_flag_in),
        .pix_color    (pix_color),
        .pix_valid    (pix_valid)
    );

    always_comb begin
        coll_now = {NUM_SPRITES{video_on & shell_flag}} & icon_flag_in & armed;
`ifdef ICON_HIT_SPRITE_COLLIDE_EN
        // Two or more flags set <=> clearing the lowest set bit leaves something.
        overlap_now = video_on && ((icon_flag_in & (icon_flag_in - NUM_SPRITES'(1))) != '0);
        coll_now    = coll_now | ({NUM_SPRITES{overlap_now}} & icon_flag_in & armed);
`endif
        pend8 = '0;
        pend8[NUM_SPRITES-1:0] = pending;
        rr8 = '0;
        rr8[RR_W-1:0] = rr_ptr;
        sel_idx = RR_W'(next_rr(pend8, rr8, NUM_SPRITES));
        sel_onehot = '0;
        sel_onehot[sel_idx] = 1'b1;
        rr_next = (32'(sel_idx) == NUM_SPRITES - 1) ? '0 : sel_idx + RR_W'(1);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            coll_acc   <= '0;
            pending    <= '0;
            armed      <= '1;
            rr_ptr     <= '0;
            frame_pend <= 1'b0;
            tank_hit   <= '0;
            hit_count  <= '0;
`ifdef ICON_HIT_SPRITE_COLLIDE_EN
            overlap_seen <= 1'b0;
`endif
        end else begin
            tank_hit <= '0;
            armed    <= armed | tank_reset_in;
            coll_acc <= coll_acc | coll_now;
`ifdef ICON_HIT_SPRITE_COLLIDE_EN
            if (overlap_now)
                overlap_seen <= 1'b1;
`endif
            if (state != IDLE && frame_start)
                frame_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (frame_start || frame_pend) begin
                        state      <= EVAL;
                        frame_pend <= 1'b0;
                    end
                end
                EVAL: begin
                    pending  <= coll_acc & armed;
                    // Same-cycle collision survives the clear.
                    coll_acc <= coll_now;
`ifdef ICON_HIT_SPRITE_COLLIDE_EN
                    overlap_seen <= overlap_now;
`endif
                    state <= ((coll_acc & armed) != '0) ? ISSUE : IDLE;
                end
                ISSUE: begin
                    if (pending == '0) begin
                        state <= IDLE;
                    end else begin
                        tank_hit <= sel_onehot;
                        pending  <= pending & ~sel_onehot;
                        armed    <= (armed | tank_reset_in) & ~sel_onehot;
                        rr_ptr   <= rr_next;
                        if (hit_count != '1)
                            hit_count <= hit_count + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icon_hit_arbiter.sv
// Self-checking bench for icon_hit_arbiter: merge table plus FSM sequences; a second
// instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_icon_hit_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        video_on;
    logic        frame_start;
    logic [47:0] icon_in;
    logic [3:0]  icon_flag_in;
    logic        shell_flag;
    logic [3:0]  tank_reset_in;

    logic [11:0] pix_color;
    logic        pix_valid;
    logic [3:0]  tank_hit;
    logic [3:0]  armed;
    logic [7:0]  hit_count;
    logic        busy;

    logic [11:0] s_pix_color;
    logic        s_pix_valid;
    logic [3:0]  s_tank_hit;
    logic [3:0]  s_armed;
    logic [1:0]  s_hit_count;
    logic        s_busy;
`ifdef ICON_HIT_SPRITE_COLLIDE_EN
    logic        overlap_seen;
    logic        s_overlap_seen;
`endif

    int checks   = 0;
    int failures = 0;
    int total_hits = 0;

    typedef struct {
        logic [3:0]  flags;
        logic [47:0] icons;
        logic        exp_valid;
        logic [11:0] exp_color;
    } mvec_t;

    typedef struct {
        logic [3:0] hit;
        logic       busy;
    } fsm_exp_t;

    mvec_t       mtab [5];
    logic [12:0] pix_q [$];
    fsm_exp_t    fsm_q [$];

    always #5 clk = ~clk;

    icon_hit_arbiter #(.NUM_SPRITES(4), .COLOR_W(12), .CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .video_on      (video_on),
        .frame_start   (frame_start),
        .icon_in       (icon_in),
        .icon_flag_in  (icon_flag_in),
        .shell_flag    (shell_flag),
        .tank_reset_in (tank_reset_in),
        .pix_color     (pix_color),
        .pix_valid     (pix_valid),
        .tank_hit      (tank_hit),
        .armed         (armed),
        .hit_count     (hit_count),
        .busy          (busy)
`ifdef ICON_HIT_SPRITE_COLLIDE_EN
        ,
        .overlap_seen  (overlap_seen)
`endif
    );

    icon_hit_arbiter #(.NUM_SPRITES(4), .COLOR_W(12), .CNT_W(2)) dut_sat (
        .clk           (clk),
        .reset         (reset),
        .video_on      (video_on),
        .frame_start   (frame_start),
        .icon_in       (icon_in),
        .icon_flag_in  (icon_flag_in),
        .shell_flag    (shell_flag),
        .tank_reset_in (tank_reset_in),
        .pix_color     (s_pix_color),
        .pix_valid     (s_pix_valid),
        .tank_hit      (s_tank_hit),
        .armed         (s_armed),
        .hit_count     (s_hit_count),
        .busy          (s_busy)
`ifdef ICON_HIT_SPRITE_COLLIDE_EN
        ,
        .overlap_seen  (s_overlap_seen)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        video_on      = 1'b0;
        shell_flag    = 1'b0;
        icon_flag_in  = '0;
        frame_start   = 1'b0;
        tank_reset_in = '0;
    endtask

    task automatic check_counts();
        check("hit_count", 32'(hit_count), (total_hits > 255) ? 255 : total_hits);
        check("sat_count", 32'(s_hit_count), (total_hits > 3) ? 3 : total_hits);
    endtask

    task automatic collide(input logic [3:0] flags);
        video_on     = 1'b1;
        shell_flag   = 1'b1;
        icon_flag_in = flags;
        tick();
        quiet();
    endtask

    task automatic rearm(input logic [3:0] m);
        tank_reset_in = m;
        tick();
        tank_reset_in = '0;
    endtask

    task automatic push_exp(input logic [3:0] hit, input logic b);
        fsm_exp_t e;
        e.hit  = hit;
        e.busy = b;
        fsm_q.push_back(e);
    endtask

    // Bit k of fs_mask is the frame_start level during the k-th clock.
    task automatic drain(input logic [7:0] fs_mask);
        fsm_exp_t e;
        int k;
        k = 0;
        while (fsm_q.size() > 0) begin
            frame_start = (k < 8) ? fs_mask[k] : 1'b0;
            tick();
            e = fsm_q.pop_front();
            check("tank_hit", 32'(tank_hit), 32'(e.hit));
            check("busy", 32'(busy), 32'(e.busy));
            check("sat_tank_hit", 32'(s_tank_hit), 32'(e.hit));
            k++;
        end
        frame_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [12:0] pe;

        mtab[0] = '{4'b0110, 48'hFFF_F00_0F0_00F, 1'b1, 12'h0F0};
        mtab[1] = '{4'b0000, 48'hFFF_F00_0F0_00F, 1'b0, 12'h000};
        mtab[2] = '{4'b1000, 48'hFFF_F00_0F0_00F, 1'b1, 12'hFFF};
        mtab[3] = '{4'b1111, 48'hFFF_F00_0F0_00F, 1'b1, 12'h00F};
        mtab[4] = '{4'b0100, 48'h123_ABC_456_789, 1'b1, 12'hABC};

        quiet();
        icon_in = 48'hFFF_F00_0F0_00F;
        reset   = 1'b0;
        icon_flag_in = 4'b0001;
        tick();
        tick();
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_pix_color", 32'(pix_color), 0);
        check("rst_tank_hit", 32'(tank_hit), 0);
        check("rst_armed", 32'(armed), 32'hF);
        check("rst_busy", 32'(busy), 0);
        check_counts();
        icon_flag_in = '0;
        reset = 1'b1;
        tick();

        // Pixel merge table
        for (int i = 0; i < 5; i++) begin
            icon_flag_in = mtab[i].flags;
            icon_in      = mtab[i].icons;
            pix_q.push_back({mtab[i].exp_valid, mtab[i].exp_color});
            tick();
            pe = pix_q.pop_front();
            check("pix_valid", 32'(pix_valid), 32'(pe[12]));
            check("pix_color", 32'(pix_color), 32'(pe[11:0]));
        end
        quiet();
        icon_in = 48'hFFF_F00_0F0_00F;
        tick();
        check("idle_busy", 32'(busy), 0);

        // Single hit on sprite 2
        collide(4'b0100);
        push_exp(4'b0000, 1'b1);
        push_exp(4'b0000, 1'b1);
        push_exp(4'b0100, 1'b1);
        push_exp(4'b0000, 1'b0);
        drain(8'b0000_0001);
        total_hits = 1;
        check_counts();
        check("armed_after_hit", 32'(armed), 32'hB);
        rearm(4'b0100);
        check("armed_rearm", 32'(armed), 32'hF);

        // Hit sprite 1 so the pointer lands on 2
        collide(4'b0010);
        push_exp(4'b0000, 1'b1);
        push_exp(4'b0000, 1'b1);
        push_exp(4'b0010, 1'b1);
        push_exp(4'b0000, 1'b0);
        drain(8'b0000_0001);
        total_hits = 2;
        check_counts();
        rearm(4'b0010);

        // Round robin from rr_ptr=2 over sprites 0,1,3
        collide(4'b1011);
        push_exp(4'b0000, 1'b1);
        push_exp(4'b0000, 1'b1);
        push_exp(4'b1000, 1'b1);
        push_exp(4'b0001, 1'b1);
        push_exp(4'b0010, 1'b1);
        push_exp(4'b0000, 1'b0);
        drain(8'b0000_0001);
        total_hits = 5;
        check_counts();
        check("armed_rr", 32'(armed), 32'h4);
        check("rr_ptr", 32'(dut.rr_ptr), 2);
        rearm(4'b1001);
        check("armed_partial", 32'(armed), 32'hD);

        // Disarmed sprite 1 is not hit
        collide(4'b0010);
        push_exp(4'b0000, 1'b1);
        push_exp(4'b0000, 1'b0);
        drain(8'b0000_0001);
        check_counts();
        check("armed_disarmed", 32'(armed), 32'hD);
        rearm(4'b0010);
        check("armed_all", 32'(armed), 32'hF);

        // frame_start while busy is serviced after returning to IDLE
        collide(4'b0001);
        push_exp(4'b0000, 1'b1);
        push_exp(4'b0000, 1'b1);
        push_exp(4'b0001, 1'b1);
        push_exp(4'b0000, 1'b0);
        push_exp(4'b0000, 1'b1);
        push_exp(4'b0000, 1'b0);
        drain(8'b0000_0011);
        total_hits = 6;
        check_counts();
        check("rr_ptr_pend", 32'(dut.rr_ptr), 1);
        rearm(4'b0001);

        // Reset in the middle of ISSUE
        collide(4'b0111);
        push_exp(4'b0000, 1'b1);
        push_exp(4'b0000, 1'b1);
        push_exp(4'b0010, 1'b1);
        drain(8'b0000_0001);
        total_hits = 7;
        check_counts();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total_hits = 0;
        check("rst_mid_tank_hit", 32'(tank_hit), 0);
        check("rst_mid_armed", 32'(armed), 32'hF);
        check("rst_mid_busy", 32'(busy), 0);
        check_counts();
        push_exp(4'b0000, 1'b0);
        push_exp(4'b0000, 1'b0);
        push_exp(4'b0000, 1'b0);
        drain(8'b0000_0000);
        push_exp(4'b0000, 1'b1);
        push_exp(4'b0000, 1'b0);
        drain(8'b0000_0001);
        check_counts();
        check("armed_final", 32'(armed), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icon_hit_arbiter.md
Name: icon_hit_arbiter

Overview:
- Sits between the per-tank icon sprite renderers and the VGA colourizer.
- Merges up to NUM_SPRITES icon layers into one pixel by fixed priority.
- Accumulates shell-versus-sprite collisions across each video frame.
- At each frame boundary, sequences one-cycle tank_hit pulses back to the renderers, one sprite per cycle, in round-robin order. Each sprite is re-armed only after its renderer reports tank_reset.

Parameters:
- NUM_SPRITES, 4, number of icon layers/tanks (2..8)
- COLOR_W, 12, pixel colour width
- CNT_W, 8, width of the saturating hit counter

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-low
- video_on  in  1  high in visible area
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- icon_in  in  NUM_SPRITES*COLOR_W  sprite colours; sprite i occupies bits [i*COLOR_W +: COLOR_W]
- icon_flag_in  in  NUM_SPRITES  sprite i opaque at current pixel
- shell_flag  in  1  projectile opaque at current pixel
- tank_reset_in  in  NUM_SPRITES  one-cycle respawn pulse from renderer i
- pix_color  out  COLOR_W  merged sprite colour
- pix_valid  out  1  merged pixel is opaque
- tank_hit  out  NUM_SPRITES  one-cycle hit pulse to renderer i
- armed  out  NUM_SPRITES  sprite i is eligible to be hit
- hit_count  out  CNT_W  total hits issued, saturating
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (reset==0 at a clk edge) sets these values:
  - pix_color=0, pix_valid=0, tank_hit=0, hit_count=0, busy=0.
  - armed = all ones; coll_acc=0; rr_ptr=0; frame_pend=0.
  - FSM goes to IDLE.
  - Reset mid-ISSUE abandons the remaining pending hits.
- Pixel merge (1-cycle latency, registered):
  - Lowest-index i with icon_flag_in[i]=1 wins: pix_color=its colour, pix_valid=1.
  - If no flag is set: pix_valid=0, pix_color=0.
  - Merge is independent of the FSM state.
- Collision accumulation, every cycle in all states:
  - coll_acc[i] |= video_on & shell_flag & icon_flag_in[i] & armed[i].
- FSM states:
  - IDLE: on frame_start or frame_pend, go to EVAL and clear frame_pend.
  - EVAL (1 cycle):
    - pending = coll_acc & armed.
    - coll_acc cleared; a collision detected in that same cycle is kept (set after clear).
    - If pending==0, go to IDLE; else go to ISSUE.
  - ISSUE: each cycle, select the first set bit of pending, searching circularly from rr_ptr. For that bit i:
    - assert tank_hit[i] for exactly 1 cycle;
    - clear pending[i] and armed[i];
    - rr_ptr = (i+1) mod NUM_SPRITES;
    - hit_count++ (holds at 2^CNT_W-1).
  - ISSUE exits to IDLE in the cycle after pending becomes 0, i.e. it lasts popcount(pending)+1 cycles.
- At most one tank_hit bit is asserted in any cycle.
- frame_start arriving while not in IDLE sets frame_pend; it is serviced on return to IDLE. Multiple pulses collapse into one.
- tank_reset_in[i]:
  - Sets armed[i] next cycle.
  - Ignored when armed[i] is already 1.
  - Rearm and issue cannot coincide, because an unarmed sprite is never issued.
- busy = (state != IDLE).

Optional Feature:
- Macro: ICON_HIT_SPRITE_COLLIDE_EN.
- When defined:
  - Sprite-versus-sprite overlap in the visible area (two or more icon_flag_in set while video_on) also marks every overlapping armed sprite in coll_acc.
  - Adds output overlap_seen (1 bit), a sticky flag set by any such overlap and cleared in EVAL.
- When undefined:
  - Only shell collisions count.
  - overlap_seen port is absent.

Decomposition:
- Package icon_hit_pkg holds:
  - FSM state enum (IDLE, EVAL, ISSUE);
  - COLOR_W default;
  - function next_rr(pending, rr_ptr) returning the selected index.
- One sub-module: icon_prio_mux (registered fixed-priority pixel merge), instantiated once.

Test Plan:
- Merge priority: icon_flag_in=4'b0110, sprite1=12'h0F0, sprite2=12'hF00 -> next cycle pix_valid=1, pix_color=12'h0F0; flags=0 -> pix_valid=0, pix_color=0.
- Single hit: shell_flag & icon_flag_in[2] during video_on, then frame_start -> EVAL, then tank_hit=4'b0100 for 1 cycle, armed=4'b1011, hit_count=1; tank_reset_in[2] pulse -> armed=4'b1111.
- Round robin: rr_ptr=2, collisions on sprites 0, 1, 3 -> tank_hit sequence 4'b1000, 4'b0001, 4'b0010 on consecutive cycles; busy high 5 cycles total (EVAL plus 4 ISSUE); rr_ptr ends at 2.
- Disarmed ignore: sprite 1 unarmed, shell overlaps it, frame_start -> no tank_hit, hit_count unchanged.
- Frame pend / reset: frame_start during ISSUE -> second EVAL follows immediately after IDLE; reset=0 mid-ISSUE -> next cycle tank_hit=0, armed=4'b1111, hit_count=0.
- Saturation (CNT_W=2): issue 5 hits -> hit_count sticks at 3.
